// File: rtl/soc_io_bus_pkg.sv
// -----------------------------------------------------------------------------
// soc_io_bus_pkg
// Shared definitions for the memory-mapped I/O interconnect:
//   - bus_state_t        : transaction FSM encoding (IDLE / ACCESS / RESP)
//   - ERR_*_BIT          : bit positions inside err_sticky
//   - DEF_IO_BASE/END    : default inclusive I/O window
//   - timeout_cnt_width  : width of the saturating per-access wait counter
// -----------------------------------------------------------------------------
package soc_io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

    localparam int unsigned ERR_TIMEOUT_BIT = 0;
    localparam int unsigned ERR_FAULT_BIT   = 1;

    localparam logic [31:0] DEF_IO_BASE = 32'h1000_0000;
    localparam logic [31:0] DEF_IO_END  = 32'h1200_0000;

    // clog2(cycles+1), never narrower than one bit so a disabled timeout
    // (cycles == 0) still yields a legal vector.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/soc_io_addr_decoder.sv
// -----------------------------------------------------------------------------
// soc_io_addr_decoder
// Purely combinational base/mask address decoder with lowest-index priority.
// Shared between the CPU port and the future DMA port.
// Ports:
//   addr       in   ADDR_WIDTH  address to decode
//   hit        out  NUM_SLAVES  one-hot match (lowest matching channel only)
//   any_hit    out  1           at least one channel matched
//   in_window  out  1           addr lies inside [IO_BASE, IO_END]
// -----------------------------------------------------------------------------
module soc_io_addr_decoder
    import soc_io_bus_pkg::*;
#(
    parameter int unsigned                        NUM_SLAVES = 8,
    parameter int unsigned                        ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK = '0,
    parameter logic [ADDR_WIDTH-1:0]              IO_BASE    = DEF_IO_BASE,
    parameter logic [ADDR_WIDTH-1:0]              IO_END     = DEF_IO_END
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit,
    output logic                  in_window
);

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit &&
                ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

    assign in_window = (addr >= IO_BASE) && (addr <= IO_END);

endmodule

// File: rtl/soc_io_bus.sv
// -----------------------------------------------------------------------------
// soc_io_bus
// Memory-mapped I/O interconnect between the CPU data port and NUM_SLAVES
// peripherals. One outstanding transaction, registered read data, per-access
// timeout, access-fault reporting outside the I/O window, sticky error bits.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_valid/addr/wstrb/wdata  CPU request (wstrb == 0 means read)
//   cpu_ready/rdata/fault    single-cycle response
//   s_valid                  one-hot request strobe to the slaves
//   s_addr/s_wstrb/s_wdata   latched request, broadcast to all slaves
//   s_ready, s_rdata         per-slave completion pulse and flattened read data
//   err_sticky, err_clr      {fault seen, timeout seen}; err_clr clears both
// -----------------------------------------------------------------------------
module soc_io_bus
    import soc_io_bus_pkg::*;
#(
    parameter int unsigned                        NUM_SLAVES     = 8,
    parameter int unsigned                        ADDR_WIDTH     = 32,
    parameter int unsigned                        DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_BASE     = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]   SLAVE_MASK     = '0,
    parameter logic [ADDR_WIDTH-1:0]              IO_BASE        = DEF_IO_BASE,
    parameter logic [ADDR_WIDTH-1:0]              IO_END         = DEF_IO_END,
    parameter int unsigned                        TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cpu_valid,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH/8-1:0]          cpu_wstrb,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    output logic                             cpu_ready,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic                             cpu_fault,
    output logic [NUM_SLAVES-1:0]            s_valid,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH/8-1:0]          s_wstrb,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                       err_sticky,
    input  logic                             err_clr
);

    localparam int unsigned CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // The counter holds the number of ACCESS cycles already completed, so the
    // last permitted cycle is the one in which it reads TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    bus_state_t              state_q, state_d;
    logic [NUM_SLAVES-1:0]   hit, sel_q;
    logic                    any_hit, in_window;
    logic                    accept, slave_done, timeout_hit;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [CNT_W-1:0]        cnt_q;
    logic                    fault_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              err_q, err_d;

    soc_io_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IO_BASE    (IO_BASE),
        .IO_END     (IO_END)
    ) u_decoder (
        .addr      (cpu_addr),
        .hit       (hit),
        .any_hit   (any_hit),
        .in_window (in_window)
    );

    // Only the selected channel's ready/data are observed.
    assign sel_ready = |(s_ready & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        slave_done  = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    accept  = 1'b1;
                    state_d = any_hit ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                // Ready takes precedence over a timeout in the same cycle.
                if (sel_ready) begin
                    slave_done = 1'b1;
                    state_d    = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_addr  <= '0;
            s_wstrb <= '0;
            s_wdata <= '0;
            sel_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                s_addr  <= cpu_addr;
                s_wstrb <= cpu_wstrb;
                s_wdata <= cpu_wdata;
                sel_q   <= hit;
                fault_q <= !any_hit && !in_window;
                rdata_q <= '0;
                cnt_q   <= '0;
            end else if (state_q == ST_ACCESS) begin
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (slave_done) begin
                    rdata_q <= (|s_wstrb) ? '0 : sel_rdata;
                    fault_q <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    fault_q <= 1'b1;
                end
            end
        end
    end

    // Clear first, then apply same-cycle sets so a set wins over err_clr.
    always_comb begin
        err_d = err_clr ? 2'b00 : err_q;
        if (timeout_hit) begin
            err_d[ERR_TIMEOUT_BIT] = 1'b1;
        end
        if ((state_q == ST_RESP) && fault_q) begin
            err_d[ERR_FAULT_BIT] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    // ---------------- Outputs ----------------
    assign s_valid    = (state_q == ST_ACCESS) ? sel_q : '0;
    assign cpu_ready  = (state_q == ST_RESP);
    assign cpu_fault  = cpu_ready & fault_q;
    assign cpu_rdata  = rdata_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_soc_io_bus.sv
// -----------------------------------------------------------------------------
// tb_soc_io_bus
// Directed bench for soc_io_bus: 4 channels, TIMEOUT_CYCLES=8.
//   ch0 0x1001_00xx, ch1 0x1000_00xx, ch2 0x1002_00xx, ch3 0x1000_xxxx
//   (ch1 and ch3 overlap on 0x1000_00xx; ch1 must win).
// Slave i always presents read data 0xA5A5_000i.
// Latency is counted with the cycle in which cpu_valid is first high as 1.
// -----------------------------------------------------------------------------
module tb_soc_io_bus;

    localparam int unsigned NS = 4;
    localparam logic [NS*32-1:0] BASES = {32'h1000_0000, 32'h1002_0000,
                                          32'h1000_0000, 32'h1001_0000};
    localparam logic [NS*32-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_FF00,
                                          32'hFFFF_FF00, 32'hFFFF_FF00};

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_valid;
    logic [31:0]       cpu_addr;
    logic [3:0]        cpu_wstrb;
    logic [31:0]       cpu_wdata;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              cpu_fault;
    logic [NS-1:0]     s_valid;
    logic [31:0]       s_addr;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_wdata;
    logic [NS-1:0]     s_ready;
    logic [NS*32-1:0]  s_rdata;
    logic [1:0]        err_sticky;
    logic              err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    assign s_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    always #5 clk = ~clk;

    soc_io_bus #(
        .NUM_SLAVES     (NS),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SLAVE_BASE     (BASES),
        .SLAVE_MASK     (MASKS),
        .IO_BASE        (32'h1000_0000),
        .IO_END         (32'h1200_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_fault  (cpu_fault),
        .s_valid    (s_valid),
        .s_addr     (s_addr),
        .s_wstrb    (s_wstrb),
        .s_wdata    (s_wdata),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU transaction. rdy_ch < 0 keeps every slave silent; otherwise
    // s_ready[rdy_ch] pulses in the (k+1)-th cycle that s_valid is seen high.
    task automatic xfer(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        input int rdy_ch, input int k,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int svn, output logic [NS-1:0] svv, output logic bc_ok);
        int  cyc;
        bit  done;
        cyc   = 0;
        done  = 1'b0;
        rd    = '0;
        flt   = 1'b0;
        lat   = 0;
        svn   = 0;
        svv   = '0;
        bc_ok = 1'b1;
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wstrb = ws;
        cpu_wdata = wd;
        while (!done && cyc < 40) begin
            cyc++;
            s_ready = '0;
            if (s_valid != '0) begin
                svn++;
                svv = svv | s_valid;
                if (s_addr !== a || s_wstrb !== ws || s_wdata !== wd) bc_ok = 1'b0;
                if (rdy_ch >= 0 && svn == k + 1) s_ready[rdy_ch] = 1'b1;
            end
            if (cpu_ready) begin
                rd   = cpu_rdata;
                flt  = cpu_fault;
                lat  = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        cpu_valid = 1'b0;
        s_ready   = '0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] a, input logic [3:0] ws,
                            input logic [31:0] wd, input int rdy_ch, input int k,
                            input logic [31:0] e_rd, input logic e_flt, input int e_lat,
                            input int e_svn, input logic [NS-1:0] e_svv);
        logic [31:0]   rd;
        logic          flt;
        int            lat, svn;
        logic [NS-1:0] svv;
        logic          bc_ok;
        xfer(a, ws, wd, rdy_ch, k, rd, flt, lat, svn, svv, bc_ok);
        chk({tag, ".rdata"},   64'(rd),  64'(e_rd));
        chk({tag, ".fault"},   64'(flt), 64'(e_flt));
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".sv_cnt"},  64'(svn), 64'(e_svn));
        chk({tag, ".sv_sel"},  64'(svv), 64'(e_svv));
        chk({tag, ".bcast"},   64'(bc_ok), 64'd1);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wstrb = '0;
        cpu_wdata = '0;
        s_ready   = '0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst.cpu_fault", 64'(cpu_fault), 64'd0);
        chk("rst.cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst.s_valid",   64'(s_valid),   64'd0);
        chk("rst.s_addr",    64'(s_addr),    64'd0);
        chk("rst.err",       64'(err_sticky), 64'd0);
        rst = 1'b0;

        // Slave read, ready 2 cycles after s_valid rises; overlap -> ch1 wins.
        run_case("rd_ch1", 32'h1000_0004, 4'h0, 32'h0, 1, 2, 32'hA5A5_0001, 1'b0, 5, 3, 4'b0010);
        // Write: response data forced to zero.
        run_case("wr_ch1", 32'h1000_0008, 4'hF, 32'h55, 1, 0, 32'h0, 1'b0, 3, 1, 4'b0010);
        // Address only in ch3's wider range.
        run_case("rd_ch3", 32'h1000_1000, 4'h0, 32'h0, 3, 1, 32'hA5A5_0003, 1'b0, 4, 2, 4'b1000);
        chk("err.after_ok", 64'(err_sticky), 64'd0);

        // Outside the window: fault, then clear.
        run_case("fault_hi", 32'h8000_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1, 2, 0, 4'b0000);
        chk("err.fault", 64'(err_sticky), 64'b10);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err.cleared", 64'(err_sticky), 64'b00);

        // Inside the window but unmatched: benign.
        run_case("unmatched", 32'h1100_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b0, 2, 0, 4'b0000);
        chk("err.unmatched", 64'(err_sticky), 64'b00);
        // Window edges (IO_END inclusive).
        run_case("win_end", 32'h1200_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b0, 2, 0, 4'b0000);
        run_case("win_past", 32'h1200_0001, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1, 2, 0, 4'b0000);
        run_case("win_below", 32'h0FFF_FFFF, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1, 2, 0, 4'b0000);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;

        // Silent slave: 8 ACCESS cycles, then timeout fault.
        run_case("timeout", 32'h1002_0010, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1, 10, 8, 4'b0100);
        chk("err.timeout", 64'(err_sticky), 64'b11);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        // Ready on the last permitted cycle wins.
        run_case("rdy_at_limit", 32'h1002_0010, 4'h0, 32'h0, 2, 7, 32'hA5A5_0002, 1'b0, 10, 8, 4'b0100);
        chk("err.limit", 64'(err_sticky), 64'b00);
        // Ready from a non-selected channel is ignored.
        run_case("wrong_rdy", 32'h1001_0000, 4'h0, 32'h0, 3, 0, 32'h0, 1'b1, 10, 8, 4'b0001);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk);
        // Set beats a simultaneous clear (err_clr held through the response).
        run_case("clr_prio", 32'h8000_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1, 2, 0, 4'b0000);
        chk("err.set_wins", 64'(err_sticky), 64'b10);
        err_clr = 1'b0;

        // Reset in the middle of ACCESS.
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = 32'h1002_0000;
        cpu_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        chk("abort.pre_sv", 64'(s_valid), 64'b0100);
        #2 rst = 1'b1;
        #1;
        chk("abort.sv_drop", 64'(s_valid), 64'd0);
        chk("abort.err", 64'(err_sticky), 64'd0);
        cpu_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ready || s_valid != '0) seen = 1'b1;
        end
        chk("abort.no_resp", 64'(seen), 64'd0);
        run_case("after_abort", 32'h1000_0004, 4'h0, 32'h0, 1, 0, 32'hA5A5_0001, 1'b0, 3, 1, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
